factorial_bcd: RTL

FACTORIAL_BCD -- requirements
Module: factorial_bcd

---
 rtl/factorial_bcd.sv | 125 ++++++++++++
 1 files changed

// File: rtl/factorial_bcd.sv
// Purpose: converts a WIDTH-bit binary value (with its overflow flag) to packed BCD by shift-and-add-3.
// Latency: start accepted at edge k, bcd/ovf_out loaded at edge k+WIDTH, done high for the following cycle.
// Backpressure: none; start is only sampled in IDLE, so a held start yields one conversion per WIDTH+2 edges.
module factorial_bcd #(
  parameter int WIDTH  = 21,
  parameter int DIGITS = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  ovf_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf_out
);

  // Counter must hold values up to WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [WIDTH-1:0]      sreg;
  logic [BW-1:0]         scratch;
  logic [BW-1:0]         adj;
  logic [BW+WIDTH-1:0]   shifted;
  logic [CW-1:0]         cnt;
  logic                  ovf_cap;
  logic                  last;

  // Add 3 to every scratch digit that is 5 or more, so the following shift carries correctly into the next digit.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // One double-dabble step: the adjusted digits and the remaining binary bits move left together.
  assign shifted = {adj, sreg} << 1;

  // The shift performed while cnt == WIDTH-1 is the WIDTH-th and final one.
  assign last = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on an accepted start, shift while converting, publish the result on the last shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      sreg    <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovf_cap <= 1'b0;
      bcd     <= '0;
      ovf_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= bin;
            ovf_cap <= ovf_in;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= shifted[BW+WIDTH-1:WIDTH];
          sreg    <= shifted[WIDTH-1:0];
          cnt     <= cnt + CW'(1);
          if (last) begin
            bcd     <= shifted[BW+WIDTH-1:WIDTH];
            ovf_out <= ovf_cap;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
